sram_fifo: RTL and testbench
============================

SRAM_FIFO -- requirements
Module: sram_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width in bits of each stored word.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 6, log2 of depth (DEPTH = 2**ADDR_WIDTH = 64 words).
REQ-003 SHALL provide parameter AFULL_LEVEL, default 56, occupancy at or above which almost_full asserts.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL provide port clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset  input  1  synchronous active-high reset.
REQ-007 SHALL provide port data  input  DATA_WIDTH  write word.
REQ-008 SHALL provide port we  input  1  push request.
REQ-009 SHALL provide port re  input  1  pop request.
REQ-010 SHALL provide port q  output  DATA_WIDTH  registered read word.
REQ-011 SHALL provide port empty  output  1  occupancy == 0.
REQ-012 SHALL provide port full  output  1  occupancy == DEPTH.
REQ-013 SHALL provide port almost_full  output  1  occupancy >= AFULL_LEVEL.
REQ-014 SHALL provide port count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-015 SHALL accept a push when we=1 and (full=0 or a pop is accepted in the same cycle), writing data at the write pointer.
REQ-016 SHALL accept a pop when re=1 and empty=0; q SHALL present the popped word exactly one cycle after the accepting edge.
REQ-017 SHALL hold q unchanged in cycles with no accepted pop.
REQ-018 SHALL ignore a push while full, absent a simultaneous pop, leaving memory, pointers and count unchanged.
REQ-019 SHALL ignore a pop while empty, including when we=1 in the same cycle; the push is still accepted.
REQ-020 SHALL leave count unchanged on simultaneous accepted push and pop, and advance both pointers.
REQ-021 SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-022 SHALL update count, empty, full and almost_full registered, valid in the cycle after the causing edge.
REQ-023 SHALL return words in strict first-in first-out order; the same-cycle push word is never bypassed to q.

Reset
REQ-024 SHALL on reset=1 at a clock edge clear both pointers and count to 0, q to 0, full and almost_full to 0, and set empty to 1.
REQ-025 SHALL give reset priority over we and re in the same cycle; requests in that cycle are discarded.
REQ-026 SHALL not clear memory contents on reset; words from before reset are never readable afterwards.

Configuration
REQ-027 SHALL, when macro SRAM_FIFO_ERR_EN is defined, add outputs overflow and underflow (1 bit each), set sticky on a rejected push or rejected pop respectively and cleared only by reset.
REQ-028 SHALL, when SRAM_FIFO_ERR_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Structure
REQ-029 SHALL place the default DATA_WIDTH, ADDR_WIDTH and AFULL_LEVEL constants in shared package sram_pkg.
REQ-030 SHALL instantiate one sub-module, sram_dp_core, a parametrised single-clock dual-port memory with a registered read port; pointer, count and flag control SHALL stay in sram_fifo.

Verification
REQ-031 SHALL verify: after reset, push 0x11,0x22,0x33, then pop three times -> q = 0x11,0x22,0x33 on the cycle after each pop, empty=1, count=0.
REQ-032 SHALL verify: push 64 words 0x00..0x3F -> full=1, count=64, almost_full=1 from count 56; a 65th push of 0xAA is ignored, and (ERR_EN) overflow=1.
REQ-033 SHALL verify: with full, simultaneous we=1 with data 0x5A and re=1 -> q=0x00, count stays 64; after 63 further pops, the next pop returns 0x5A.
REQ-034 SHALL verify: with empty, we=1 with data 0x77 and re=1 -> pop ignored, count=1, q unchanged; (ERR_EN) underflow=1.
REQ-035 SHALL verify wrap-around: 100 interleaved push/pop of an incrementing pattern -> output sequence matches input with no loss past pointer 63->0.
REQ-036 SHALL verify: reset asserted with count=10 and we=re=1 -> next cycle count=0, empty=1, q=0, and flags cleared.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared defaults for the SRAM-backed FIFO and its dual-port memory core.
package sram_pkg;

    localparam int unsigned DefaultDataWidth  = 8;
    localparam int unsigned DefaultAddrWidth  = 6;
    localparam int unsigned DefaultAfullLevel = 56;

endpackage

// File: rtl/sram_dp_core.sv
// Single-clock dual-port memory: one write port, one read port with a registered output.
module sram_dp_core
    import sram_pkg::*;
#(
    parameter int unsigned DataWidth = DefaultDataWidth,
    parameter int unsigned AddrWidth = DefaultAddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] rdata_q;

    // Storage is never reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-address write this edge is not bypassed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_fifo.sv
// Synchronous FIFO over sram_dp_core with registered occupancy flags.
// Define SRAM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sram_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
    parameter int unsigned AFULL_LEVEL = DefaultAfullLevel
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef SRAM_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AfullCnt = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q, afull_q;
    logic                  push_ok, pop_ok;

    always_comb begin
        pop_ok  = re && !empty_q;
        push_ok = we && (!full_q || pop_ok);
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DepthCnt);
            afull_q <= (count_d >= AfullCnt);
        end
    end

    sram_dp_core #(
        .DataWidth(DATA_WIDTH),
        .AddrWidth(ADDR_WIDTH)
    ) u_core (
        .clk_i  (clock),
        .rst_i  (reset),
        .we_i   (push_ok && !reset),
        .waddr_i(wptr_q),
        .wdata_i(data),
        .re_i   (pop_ok && !reset),
        .raddr_i(rptr_q),
        .rdata_o(q)
    );

    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;

`ifdef SRAM_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (we && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (re && !pop_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sram_fifo.sv
// Directed bench for sram_fifo: vector table plus hand-written fill, wrap and reset sequences.
module tb_sram_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data  = '0;
    logic       we    = 1'b0;
    logic       re    = 1'b0;
    logic [7:0] q;
    logic       empty, full, almost_full;
    logic [6:0] count;
`ifdef SRAM_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sram_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .we         (we),
        .re         (re),
        .q          (q),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count)
`ifdef SRAM_FIFO_ERR_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic       re;
        logic [7:0] data;
        logic [7:0] q;
        logic       empty;
        logic       full;
        logic       afull;
        logic [6:0] count;
        logic       uflow;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 time unit past the rise.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        @(negedge clock);
        reset = r;
        we    = w;
        re    = rd;
        data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string nm, input logic [7:0] eq, input logic ee,
                               input logic ef, input logic ea, input logic [6:0] ec);
        check({nm, ".q"}, 32'(q), 32'(eq));
        check({nm, ".empty"}, 32'(empty), 32'(ee));
        check({nm, ".full"}, 32'(full), 32'(ef));
        check({nm, ".afull"}, 32'(almost_full), 32'(ea));
        check({nm, ".count"}, 32'(count), 32'(ec));
    endtask

    initial begin
        logic [7:0] mq[$];
        logic [7:0] exp_q;
        logic       pop_ok, push_ok, w, r;
        int         guard;

        vecs[0]  = '{rst:1, we:0, re:0, data:8'h00, q:8'h00, empty:1, full:0, afull:0, count:0, uflow:0};
        vecs[1]  = '{rst:0, we:1, re:0, data:8'h11, q:8'h00, empty:0, full:0, afull:0, count:1, uflow:0};
        vecs[2]  = '{rst:0, we:1, re:0, data:8'h22, q:8'h00, empty:0, full:0, afull:0, count:2, uflow:0};
        vecs[3]  = '{rst:0, we:1, re:0, data:8'h33, q:8'h00, empty:0, full:0, afull:0, count:3, uflow:0};
        vecs[4]  = '{rst:0, we:0, re:1, data:8'h00, q:8'h11, empty:0, full:0, afull:0, count:2, uflow:0};
        vecs[5]  = '{rst:0, we:0, re:1, data:8'h00, q:8'h22, empty:0, full:0, afull:0, count:1, uflow:0};
        vecs[6]  = '{rst:0, we:0, re:1, data:8'h00, q:8'h33, empty:1, full:0, afull:0, count:0, uflow:0};
        vecs[7]  = '{rst:0, we:0, re:1, data:8'h00, q:8'h33, empty:1, full:0, afull:0, count:0, uflow:1};
        vecs[8]  = '{rst:0, we:1, re:1, data:8'h77, q:8'h33, empty:0, full:0, afull:0, count:1, uflow:1};
        vecs[9]  = '{rst:0, we:0, re:0, data:8'h00, q:8'h33, empty:0, full:0, afull:0, count:1, uflow:1};
        vecs[10] = '{rst:0, we:0, re:1, data:8'h00, q:8'h77, empty:1, full:0, afull:0, count:0, uflow:1};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].data);
            check_state($sformatf("vec%0d", i), vecs[i].q, vecs[i].empty, vecs[i].full,
                        vecs[i].afull, vecs[i].count);
`ifdef SRAM_FIFO_ERR_EN
            check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].uflow));
            check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'd0);
`endif
        end

        // Fill to full, then a rejected push.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check_state($sformatf("fill%0d", i), 8'h00, 1'b0, (i == 63), (i + 1 >= 56), 7'(i + 1));
        end
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        check_state("push_full", 8'h00, 1'b0, 1'b1, 1'b1, 7'd64);
`ifdef SRAM_FIFO_ERR_EN
        check("push_full.overflow", 32'(overflow), 32'd1);
`endif

        // Push and pop together while full.
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        check_state("full_pushpop", 8'h00, 1'b0, 1'b1, 1'b1, 7'd64);
        for (int i = 1; i < 64; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d.q", i), 32'(q), 32'(i));
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("drain_last", 8'h5A, 1'b1, 1'b0, 1'b0, 7'd0);

        // Interleaved traffic crossing the 63->0 pointer wrap, checked against a queue model.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        exp_q = 8'h00;
        for (int k = 0; k < 100; k++) begin
            w = 1'b1;
            r = (k % 3 != 0);
            pop_ok  = r && (mq.size() > 0);
            push_ok = w && (mq.size() < 64 || pop_ok);
            step(1'b0, w, r, 8'(k + 8'h40));
            if (pop_ok) exp_q = mq.pop_front();
            if (push_ok) mq.push_back(8'(k + 8'h40));
            check($sformatf("wrap%0d.q", k), 32'(q), 32'(exp_q));
            check($sformatf("wrap%0d.count", k), 32'(count), 32'(mq.size()));
        end
        guard = 0;
        while (mq.size() > 0 && guard < 200) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            exp_q = mq.pop_front();
            check($sformatf("wrapdrain%0d.q", guard), 32'(q), 32'(exp_q));
            guard++;
        end
        check("wrapdrain.empty", 32'(empty), 32'd1);

        // Reset with traffic pending and requests active in the same cycle.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("pre_reset", 8'hC0, 1'b0, 1'b0, 1'b0, 7'd10);
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        check_state("reset_busy", 8'h00, 1'b1, 1'b0, 1'b0, 7'd0);
`ifdef SRAM_FIFO_ERR_EN
        check("reset_busy.overflow", 32'(overflow), 32'd0);
        check("reset_busy.underflow", 32'(underflow), 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_reset", 8'h99, 1'b1, 1'b0, 1'b0, 7'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
